// File: rtl/gray_frame_ctrl.sv
// Frame-level sequencer for the RGB-to-grayscale datapath: streams a byte-interleaved
// RGB frame into the gray unit and writes each gray result to a linear pixel address.
module gray_frame_ctrl #(
    parameter int WIDTH    = 300,
    parameter int HEIGHT   = 400,
    parameter int GRAY_LAT = 1,
    parameter int RA_W     = 19,
    parameter int WA_W     = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            rgb_rd_en,
    output logic [RA_W-1:0] rgb_rd_addr,
    input  logic [7:0]      rgb_rd_data,
    output logic [7:0]      red_out,
    output logic [7:0]      green_out,
    output logic [7:0]      blue_out,
    output logic            pix_valid,
    input  logic [7:0]      gray_in,
    output logic            gray_wr_en,
    output logic [WA_W-1:0] gray_wr_addr,
    output logic [7:0]      gray_wr_data
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam logic [RA_W-1:0] RD_LAST = RA_W'(3 * NPIX - 1);
    localparam logic [WA_W-1:0] WR_LAST = WA_W'(NPIX - 1);
    localparam logic [RA_W-1:0] RD_ONE  = {{(RA_W-1){1'b0}}, 1'b1};
    localparam logic [WA_W-1:0] WR_ONE  = {{(WA_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic            clear_s;
    logic            accept_s;
    logic            last_wr_s;
    logic            tap_s;
    logic            rd_vld_r;
    logic [1:0]      phase_r;
    logic [7:0]      r_hold_r;
    logic [7:0]      g_hold_r;
    logic [WA_W-1:0] wr_cnt_r;

    // Abort only matters once a pass is under way; in IDLE it merely blocks start.
    assign clear_s   = abort && (state_r != IDLE);
    assign accept_s  = (state_r == IDLE) && start && !abort;
    assign last_wr_s = gray_wr_en && (gray_wr_addr == WR_LAST);

    // Frame sequencing FSM: read address generation, busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rgb_rd_en   <= 1'b0;
            rgb_rd_addr <= {RA_W{1'b0}};
        end else if (clear_s) begin
            state_r     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rgb_rd_en   <= 1'b0;
            rgb_rd_addr <= {RA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (accept_s) begin
                        state_r     <= RUN;
                        busy        <= 1'b1;
                        rgb_rd_en   <= 1'b1;
                        rgb_rd_addr <= {RA_W{1'b0}};
                    end else begin
                        busy      <= 1'b0;
                        rgb_rd_en <= 1'b0;
                    end
                end
                RUN: begin
                    if (rgb_rd_addr == RD_LAST) begin
                        state_r   <= DRAIN;
                        rgb_rd_en <= 1'b0;
                    end else begin
                        rgb_rd_addr <= rgb_rd_addr + RD_ONE;
                    end
                end
                DRAIN: begin
                    // The last write is already on the output port; done follows it.
                    if (last_wr_s) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    done        <= 1'b0;
                    rgb_rd_addr <= {RA_W{1'b0}};
                end
                default: begin
                    state_r     <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    rgb_rd_en   <= 1'b0;
                    rgb_rd_addr <= {RA_W{1'b0}};
                end
            endcase
        end
    end

    // Byte-to-pixel assembly: R and G are held until B completes the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_r  <= 1'b0;
            phase_r   <= 2'd0;
            r_hold_r  <= 8'd0;
            g_hold_r  <= 8'd0;
            red_out   <= 8'd0;
            green_out <= 8'd0;
            blue_out  <= 8'd0;
            pix_valid <= 1'b0;
        end else if (clear_s) begin
            rd_vld_r  <= 1'b0;
            phase_r   <= 2'd0;
            r_hold_r  <= 8'd0;
            g_hold_r  <= 8'd0;
            red_out   <= 8'd0;
            green_out <= 8'd0;
            blue_out  <= 8'd0;
            pix_valid <= 1'b0;
        end else begin
            rd_vld_r  <= rgb_rd_en;
            pix_valid <= 1'b0;
            if (accept_s) begin
                phase_r <= 2'd0;
            end else if (rd_vld_r) begin
                case (phase_r)
                    2'd0: begin
                        r_hold_r <= rgb_rd_data;
                        phase_r  <= 2'd1;
                    end
                    2'd1: begin
                        g_hold_r <= rgb_rd_data;
                        phase_r  <= 2'd2;
                    end
                    2'd2: begin
                        red_out   <= r_hold_r;
                        green_out <= g_hold_r;
                        blue_out  <= rgb_rd_data;
                        pix_valid <= 1'b1;
                        phase_r   <= 2'd0;
                    end
                    default: begin
                        phase_r <= 2'd0;
                    end
                endcase
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    generate
        if (GRAY_LAT == 0) begin : g_no_dly
            assign tap_s = pix_valid;
        end else begin : g_dly
            logic [GRAY_LAT-1:0] dly_r;

            // Valid delay line matching the gray unit's pipeline depth.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly_r <= {GRAY_LAT{1'b0}};
                end else if (clear_s) begin
                    dly_r <= {GRAY_LAT{1'b0}};
                end else begin
                    dly_r[0] <= pix_valid;
                    for (int i = 1; i < GRAY_LAT; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end

            assign tap_s = dly_r[GRAY_LAT-1];
        end
    endgenerate

    // Output write port: capture gray result and assign the next linear address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_wr_en   <= 1'b0;
            gray_wr_addr <= {WA_W{1'b0}};
            gray_wr_data <= 8'd0;
            wr_cnt_r     <= {WA_W{1'b0}};
        end else if (clear_s) begin
            gray_wr_en   <= 1'b0;
            gray_wr_addr <= {WA_W{1'b0}};
            gray_wr_data <= 8'd0;
            wr_cnt_r     <= {WA_W{1'b0}};
        end else if (accept_s) begin
            gray_wr_en <= 1'b0;
            wr_cnt_r   <= {WA_W{1'b0}};
        end else if (tap_s) begin
            gray_wr_en   <= 1'b1;
            gray_wr_addr <= wr_cnt_r;
            gray_wr_data <= gray_in;
            wr_cnt_r     <= (wr_cnt_r == WR_LAST) ? wr_cnt_r : (wr_cnt_r + WR_ONE);
        end else begin
            gray_wr_en <= 1'b0;
        end
    end

endmodule
